// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button event controller.
package btn_pkg;

  localparam logic [1:0] ADDR_LEVEL   = 2'd0;
  localparam logic [1:0] ADDR_PRESS   = 2'd1;
  localparam logic [1:0] ADDR_RELEASE = 2'd2;
  localparam logic [1:0] ADDR_IRQEN   = 2'd3;

  typedef enum logic [1:0] {
    LO      = 2'd0,
    WAIT_HI = 2'd1,
    HI      = 2'd2,
    WAIT_LO = 2'd3
  } db_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability-counter debounce FSM,
// and registered one-cycle press/release pulses.
//
// state   | meaning
// LO      | debounced level 0, input agrees
// WAIT_HI | level 0, input high, counting stable cycles
// HI      | debounced level 1, input agrees
// WAIT_LO | level 1, input low, counting stable cycles
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  db_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             r_release;

  db_state_t        w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_state   <= LO;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_btn_raw;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // The count exits at CNT_TC, so the increment can never wrap.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      LO: begin
        if (r_sync2) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (!r_sync2) begin
          w_state_nxt = LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_TC) begin
          w_state_nxt = HI;
          w_cnt_nxt   = '0;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      HI: begin
        if (!r_sync2) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (r_sync2) begin
          w_state_nxt = HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_TC) begin
          w_state_nxt   = LO;
          w_cnt_nxt     = '0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = LO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_level   = (r_state == HI) || (r_state == WAIT_LO);
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/btn_event_ctrl.sv
// N-channel button front end: per-channel debounce plus sticky press/release
// flags, interrupt enable and a word-addressed MMIO register port.
module btn_event_ctrl
  import btn_pkg::*;
#(
  parameter int NUM_CH    = 5,
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] btn_raw,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_press,
  output logic [NUM_CH-1:0] btn_release,
  input  logic              mmio_rd,
  input  logic              mmio_wr,
  input  logic [1:0]        mmio_addr,
  input  logic [31:0]       mmio_wdata,
  output logic [31:0]       mmio_rdata,
  output logic              irq
);

  logic [NUM_CH-1:0] r_press_st;
  logic [NUM_CH-1:0] r_release_st;
  logic [NUM_CH-1:0] r_irq_en;
  logic [31:0]       r_rdata;

  logic [NUM_CH-1:0] w_wdata_ch;
  logic [NUM_CH-1:0] w_clr_press;
  logic [NUM_CH-1:0] w_clr_release;
  logic              w_wr_irqen;
  logic [31:0]       w_rd_mux;
  logic              w_unused;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_btn_raw (btn_raw[g]),
      .o_level   (btn_level[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g])
    );
  end

  assign w_wdata_ch    = mmio_wdata[NUM_CH-1:0];
  assign w_clr_press   = (mmio_wr && mmio_addr == ADDR_PRESS)   ? w_wdata_ch : '0;
  assign w_clr_release = (mmio_wr && mmio_addr == ADDR_RELEASE) ? w_wdata_ch : '0;
  assign w_wr_irqen    = mmio_wr && (mmio_addr == ADDR_IRQEN);
  assign w_unused      = ^mmio_wdata;

  always_comb begin
    w_rd_mux = '0;
    case (mmio_addr)
      ADDR_LEVEL:   w_rd_mux = 32'(btn_level);
      ADDR_PRESS:   w_rd_mux = 32'(r_press_st);
      ADDR_RELEASE: w_rd_mux = 32'(r_release_st);
      ADDR_IRQEN:   w_rd_mux = 32'(r_irq_en);
      default:      w_rd_mux = '0;
    endcase
  end

  // A set in the same cycle as a W1C clear wins; read data is the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_press_st   <= '0;
      r_release_st <= '0;
      r_irq_en     <= '0;
      r_rdata      <= '0;
    end else begin
      r_press_st   <= (r_press_st & ~w_clr_press) | btn_press;
      r_release_st <= (r_release_st & ~w_clr_release) | btn_release;
      if (w_wr_irqen) r_irq_en <= w_wdata_ch;
      if (mmio_rd)    r_rdata  <= w_rd_mux;
    end
  end

  assign mmio_rdata = r_rdata;
  assign irq        = |(r_press_st & r_irq_en);

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Self-checking bench for btn_event_ctrl: directed scenarios plus random
// stimulus, compared every cycle against a run-length reference model.
module tb_btn_event_ctrl;

  localparam int NCH = 4;
  localparam int DB  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NCH-1:0]  btn_raw = '0;
  logic [NCH-1:0]  btn_level, btn_press, btn_release;
  logic            mmio_rd = 1'b0;
  logic            mmio_wr = 1'b0;
  logic [1:0]      mmio_addr = 2'd0;
  logic [31:0]     mmio_wdata = '0;
  logic [31:0]     mmio_rdata;
  logic            irq;

  int n_cmp = 0;
  int n_bad = 0;

  btn_event_ctrl #(.NUM_CH(NCH), .DB_CYCLES(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .mmio_rd     (mmio_rd),
    .mmio_wr     (mmio_wr),
    .mmio_addr   (mmio_addr),
    .mmio_wdata  (mmio_wdata),
    .mmio_rdata  (mmio_rdata),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // Reference model: raw pin seen by the debouncer two edges late; level flips
  // after DB consecutive samples disagreeing with it.
  bit [NCH-1:0] m_pipe[2];
  bit [NCH-1:0] m_level, m_press, m_release, m_pst, m_rst_st, m_en;
  bit [31:0]    m_rdata;
  int           m_run[NCH];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit [NCH-1:0] seen, np, nr, clr_p, clr_r;
    bit [31:0]    rd_old;
    if (rst) begin
      m_pipe[0] = '0; m_pipe[1] = '0;
      m_level = '0; m_press = '0; m_release = '0;
      m_pst = '0; m_rst_st = '0; m_en = '0; m_rdata = '0;
      for (int c = 0; c < NCH; c++) m_run[c] = 0;
      return;
    end
    seen = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = btn_raw;
    case (mmio_addr)
      2'd0:    rd_old = 32'(m_level);
      2'd1:    rd_old = 32'(m_pst);
      2'd2:    rd_old = 32'(m_rst_st);
      default: rd_old = 32'(m_en);
    endcase
    clr_p = (mmio_wr && mmio_addr == 2'd1) ? mmio_wdata[NCH-1:0] : '0;
    clr_r = (mmio_wr && mmio_addr == 2'd2) ? mmio_wdata[NCH-1:0] : '0;
    m_pst    = (m_pst & ~clr_p) | m_press;
    m_rst_st = (m_rst_st & ~clr_r) | m_release;
    if (mmio_wr && mmio_addr == 2'd3) m_en = mmio_wdata[NCH-1:0];
    if (mmio_rd) m_rdata = rd_old;
    np = '0; nr = '0;
    for (int c = 0; c < NCH; c++) begin
      if (seen[c] != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] == DB) begin
          m_level[c] = seen[c];
          if (seen[c]) np[c] = 1'b1; else nr[c] = 1'b1;
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    m_press = np;
    m_release = nr;
  endtask

  task automatic compare_all();
    check_val("level",   32'(btn_level),   32'(m_level));
    check_val("press",   32'(btn_press),   32'(m_press));
    check_val("release", 32'(btn_release), 32'(m_release));
    check_val("irq",     32'(irq),         32'(|(m_pst & m_en)));
    check_val("rdata",   mmio_rdata,       m_rdata);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  task automatic mmio_write(input logic [1:0] a, input logic [31:0] d);
    mmio_wr = 1'b1; mmio_addr = a; mmio_wdata = d;
    step();
    mmio_wr = 1'b0;
  endtask

  task automatic mmio_read(input logic [1:0] a, output logic [31:0] d);
    mmio_rd = 1'b1; mmio_addr = a;
    step();
    mmio_rd = 1'b0;
    d = mmio_rdata;
  endtask

  logic [31:0] rd;

  initial begin
    // reset state
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    check_val("rst_level", 32'(btn_level), 32'h0);
    check_val("rst_rdata", mmio_rdata, 32'h0);
    check_val("rst_irq", 32'(irq), 32'h0);

    // clean press on ch0: level exactly 6 edges after the raw change
    btn_raw[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("press_early_level", 32'(btn_level[0]), 32'h0);
    end
    step();
    check_val("press_level", 32'(btn_level[0]), 32'h1);
    check_val("press_pulse", 32'(btn_press[0]), 32'h1);
    step();
    check_val("press_pulse_end", 32'(btn_press[0]), 32'h0);
    step(13);
    mmio_read(2'd1, rd);
    check_val("press_reg", rd, 32'h1);
    btn_raw[0] = 1'b0;
    step(8);
    mmio_write(2'd1, 32'hF);
    mmio_write(2'd2, 32'hF);

    // glitch on ch1 shorter than the debounce window
    btn_raw[1] = 1'b1;
    step(3);
    btn_raw[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("glitch_level", 32'(btn_level[1]), 32'h0);
    end
    mmio_read(2'd1, rd);
    check_val("glitch_press_reg", rd, 32'h0);

    // W1C clear coinciding with a press pulse: set wins
    btn_raw[0] = 1'b1;
    step(6);
    check_val("race_pulse", 32'(btn_press[0]), 32'h1);
    mmio_write(2'd1, 32'h1);
    mmio_read(2'd1, rd);
    check_val("race_press_kept", rd, 32'h1);
    mmio_write(2'd1, 32'h1);
    mmio_read(2'd1, rd);
    check_val("race_press_cleared", rd, 32'h0);

    // release + irq on ch2
    mmio_write(2'd3, 32'h4);
    btn_raw[2] = 1'b1;
    step(8);
    check_val("irq_set", 32'(irq), 32'h1);
    btn_raw[2] = 1'b0;
    step(8);
    mmio_read(2'd2, rd);
    check_val("release_reg", rd, 32'h4);
    mmio_write(2'd1, 32'hF);
    check_val("irq_clear", 32'(irq), 32'h0);

    // reset during a debounce count
    btn_raw = '0;
    step(8);
    btn_raw[3] = 1'b1;
    step(4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("rstmid_level", 32'(btn_level[3]), 32'h0);
      check_val("rstmid_press", 32'(btn_press), 32'h0);
    end
    step();
    check_val("rstmid_level_up", 32'(btn_level[3]), 32'h1);

    // simultaneous press on ch0 and ch3
    btn_raw = '0;
    step(8);
    mmio_write(2'd1, 32'hF);
    btn_raw = 4'b1001;
    step(6);
    check_val("multi_pulse", 32'(btn_press), 32'h9);
    step();
    mmio_read(2'd1, rd);
    check_val("multi_press_reg", rd, 32'h9);
    mmio_read(2'd0, rd);
    check_val("multi_level_reg", rd, 32'h9);

    // random phase
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 9) == 0) btn_raw[c] = ~btn_raw[c];
      mmio_rd    = ($urandom_range(0, 3) == 0);
      mmio_wr    = ($urandom_range(0, 5) == 0);
      mmio_addr  = 2'($urandom_range(0, 3));
      mmio_wdata = $urandom;
      rst        = ($urandom_range(0, 399) == 0);
      step();
    end
    mmio_rd = 1'b0; mmio_wr = 1'b0; rst = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
